output_unloader: RTL and testbench

Reads the equalized image back out of the output memory after the output pipeline has finished writing it. It fetches 128-bit words (16 pixels each) by address and serializes them into an 8-bit pixel stream with a valid/ready handshake toward the host/readback port. It is the read-side counterpart of the pipeline's store stage and shares the same memory word format and the same 16-bit word addressing.

---
 rtl/output_unload_pkg.sv | 24 ++
 rtl/byte_serializer.sv | 64 ++++++
 rtl/output_unloader.sv | 183 ++++++++++++++++++
 tb/tb_output_unloader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/output_unload_pkg.sv
// ============================================================================
// output_unload_pkg : shared widths and FSM state type for the output unloader
// Rev 1.0
// ============================================================================
`default_nettype none

package output_unload_pkg;

  localparam int WORD_W         = 128;
  localparam int ADDR_W         = 16;
  localparam int PIX_W          = 8;
  localparam int BYTES_PER_WORD = 16;
  localparam int IDX_W          = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } unload_state_e;

endpackage

`default_nettype wire

// File: rtl/byte_serializer.sv
// ============================================================================
// byte_serializer : 128-bit shift word emitted byte 0 first over valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

module byte_serializer
  import output_unload_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  output logic              accept,
  output logic              last_accept,
  output logic              free
);

  logic [WORD_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;

  assign accept      = valid_q && pix_ready;
  assign last_accept = accept && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  // A new word may be loaded when empty or when the final byte leaves this cycle
  assign free        = !valid_q || last_accept;
  assign pix_out     = shift_q[{idx_q, 3'b000} +: PIX_W];
  assign pix_valid   = valid_q;

  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (load) begin
      shift_d = load_word;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (accept) begin
      if (last_accept) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/output_unloader.sv
// ============================================================================
// output_unloader : reads output memory words and streams them as pixel bytes
// Optional OUTPUT_UNLOAD_CHECKSUM_EN adds a 16-bit running byte sum. Rev 1.0
// ============================================================================
`default_nettype none

module output_unloader
  import output_unload_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] NumWords,
  input  logic [WORD_W-1:0] Output_ReadBus,
  output logic [ADDR_W-1:0] Output_ReadAddress,
  output logic [PIX_W-1:0]  PixelOut,
  output logic              PixelValid,
  input  logic              PixelReady,
  output logic              Busy,
`ifdef OUTPUT_UNLOAD_CHECKSUM_EN
  output logic [15:0]       Checksum,
`endif
  output logic              done
);

  unload_state_e     state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              iss_q, iss_d;
  logic              land_q, land_d;
  logic [WORD_W-1:0] pf_q, pf_d;
  logic              pf_valid_q, pf_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ser_load;
  logic [WORD_W-1:0] ser_word;
  logic              ser_accept;
  logic              ser_last;
  logic              ser_free;

  byte_serializer u_ser (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (ser_load),
    .load_word   (ser_word),
    .pix_ready   (PixelReady),
    .pix_out     (PixelOut),
    .pix_valid   (PixelValid),
    .accept      (ser_accept),
    .last_accept (ser_last),
    .free        (ser_free)
  );

  // iss_q: address on the bus this cycle; land_q: its data on the bus this cycle.
  // At most one read is outstanding, so a landing word always has a free slot.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    iss_d      = 1'b0;
    land_d     = iss_q;
    pf_d       = pf_q;
    pf_valid_d = pf_valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ser_load   = 1'b0;
    ser_word   = Output_ReadBus;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (NumWords == '0) begin
            state_d = FINISH;
          end else begin
            addr_d  = '0;
            rem_d   = NumWords - ADDR_W'(1);
            iss_d   = 1'b1;
            state_d = FETCH;
          end
        end
      end

      FETCH, STREAM: begin
        if ((rem_q != '0) && !pf_valid_q && !iss_q && !land_q) begin
          iss_d  = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          rem_d  = rem_q - ADDR_W'(1);
        end
        if (ser_free) begin
          if (pf_valid_q) begin
            ser_load   = 1'b1;
            ser_word   = pf_q;
            pf_valid_d = 1'b0;
            state_d    = STREAM;
          end else if (land_q) begin
            ser_load = 1'b1;
            state_d  = STREAM;
          end else if (ser_last) begin
            if ((rem_q == '0) && !iss_q) begin
              state_d = FINISH;
              done_d  = 1'b1;
            end else begin
              state_d = FETCH;
            end
          end
        end else if (land_q) begin
          pf_d       = Output_ReadBus;
          pf_valid_d = 1'b1;
        end
      end

      FINISH: begin
        // Zero-length unloads arrive here without done raised yet
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      iss_q      <= 1'b0;
      land_q     <= 1'b0;
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      iss_q      <= iss_d;
      land_q     <= land_d;
      pf_q       <= pf_d;
      pf_valid_q <= pf_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign Output_ReadAddress = addr_q;
  assign Busy               = busy_q;
  assign done               = done_q;

`ifdef OUTPUT_UNLOAD_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if ((state_q == IDLE) && start) begin
      sum_d = '0;
    end else if (ser_accept) begin
      sum_d = sum_q + {8'd0, PixelOut};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign Checksum = sum_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_output_unloader.sv
// ============================================================================
// tb_output_unloader : directed self-checking bench for output_unloader
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_output_unloader;

  logic         clock;
  logic         reset_n;
  logic         start;
  logic [15:0]  NumWords;
  logic [127:0] Output_ReadBus;
  logic [15:0]  Output_ReadAddress;
  logic [7:0]   PixelOut;
  logic         PixelValid;
  logic         PixelReady;
  logic         Busy;
  logic         done;
`ifdef OUTPUT_UNLOAD_CHECKSUM_EN
  logic [15:0]  Checksum;
`endif

  output_unloader dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .start              (start),
    .NumWords           (NumWords),
    .Output_ReadBus     (Output_ReadBus),
    .Output_ReadAddress (Output_ReadAddress),
    .PixelOut           (PixelOut),
    .PixelValid         (PixelValid),
    .PixelReady         (PixelReady),
    .Busy               (Busy),
`ifdef OUTPUT_UNLOAD_CHECKSUM_EN
    .Checksum           (Checksum),
`endif
    .done               (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous memory: address seen at an edge returns data in the next cycle
  logic [127:0] mem [0:7];
  always @(posedge clock) Output_ReadBus <= mem[Output_ReadAddress[2:0]];

  int n_err    = 0;
  int n_checks = 0;

  logic [7:0]  got[$];
  logic [15:0] addr_seq[$];
  int first_v, last_v, valid_cnt, done_cyc, done_cnt, stall_bad, max_addr;
  logic busy_at_done, busy_after;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic ready_at(input int mode, input int n);
    if (mode == 0) return 1'b1;
    return ((n % 4) == 0) || ((n % 4) == 3);
  endfunction

  function automatic int byte_errs(input int nbytes);
    int e;
    logic [127:0] w;
    e = 0;
    for (int j = 0; j < got.size() && j < nbytes; j++) begin
      w = mem[j / 16];
      if (got[j] !== w[8 * (j % 16) +: 8]) e++;
    end
    return e;
  endfunction

  function automatic int addr_errs(input int nw);
    int e;
    e = (addr_seq.size() != nw) ? 1 : 0;
    for (int i = 0; i < addr_seq.size() && i < nw; i++) begin
      if (addr_seq[i] !== 16'(i)) e++;
    end
    return e;
  endfunction

  // Drive one unload; cycle n is the n-th cycle after the edge that samples start
  task automatic run_unload(input int nw, input int mode, input int restart_at);
    logic [7:0] prev_pix;
    logic       prev_stall;
    got.delete();
    addr_seq.delete();
    first_v = -1; last_v = -1; valid_cnt = 0; done_cyc = -1; done_cnt = 0;
    stall_bad = 0; max_addr = 0; busy_at_done = 1'b0; busy_after = 1'b1;
    prev_stall = 1'b0; prev_pix = 8'd0;
    @(negedge clock);
    start = 1'b1; NumWords = 16'(nw); PixelReady = ready_at(mode, 0);
    @(negedge clock);
    start = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      if (prev_stall && (!PixelValid || PixelOut !== prev_pix)) stall_bad++;
      if (addr_seq.size() == 0 || addr_seq[$] != Output_ReadAddress)
        addr_seq.push_back(Output_ReadAddress);
      if (int'(Output_ReadAddress) > max_addr) max_addr = int'(Output_ReadAddress);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = n; busy_at_done = Busy; end
      end
      if (done_cyc >= 0 && n == done_cyc + 1) busy_after = Busy;
      if (PixelValid) begin
        valid_cnt++;
        if (first_v < 0) first_v = n;
        last_v = n;
      end
      PixelReady = ready_at(mode, n);
      if (n == restart_at) begin start = 1'b1; NumWords = 16'd5; end
      else start = 1'b0;
      if (PixelValid && PixelReady) got.push_back(PixelOut);
      prev_stall = PixelValid && !PixelReady;
      prev_pix   = PixelOut;
      if (done_cyc >= 0 && n == done_cyc + 3) break;
      @(negedge clock);
    end
    start = 1'b0;
    PixelReady = 1'b1;
    check("done_seen", (done_cyc >= 0) ? 1 : 0, 1);
  endtask

  initial begin
    int cnt;
    for (int w = 0; w < 8; w++)
      for (int b = 0; b < 16; b++) mem[w][8 * b +: 8] = 8'(w * 16 + b);

    reset_n = 1'b0; start = 1'b0; NumWords = 16'd0; PixelReady = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_addr",  32'(Output_ReadAddress), 0);
    check("rst_pix",   32'(PixelOut), 0);
    check("rst_valid", 32'(PixelValid), 0);
    check("rst_busy",  32'(Busy), 0);
    check("rst_done",  32'(done), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Single word
    run_unload(1, 0, 0);
    check("w1_count", got.size(), 16);
    check("w1_bytes", byte_errs(16), 0);
    check("w1_first_valid", first_v, 3);
    check("w1_last_valid", last_v, 18);
    check("w1_done_cycle", done_cyc, 19);
    check("w1_done_count", done_cnt, 1);
    check("w1_max_addr", max_addr, 0);
    check("w1_busy_at_done", 32'(busy_at_done), 1);
    check("w1_busy_after", 32'(busy_after), 0);

    // Multi-word streaming without gaps
    run_unload(4, 0, 0);
    check("w4_count", got.size(), 64);
    check("w4_bytes", byte_errs(64), 0);
    check("w4_first_valid", first_v, 3);
    check("w4_valid_cycles", valid_cnt, 64);
    check("w4_last_valid", last_v, 66);
    check("w4_done_cycle", done_cyc, 67);
    check("w4_addr_seq", addr_errs(4), 0);

    // Backpressure 1,0,0,1
    run_unload(2, 1, 0);
    check("bp_count", got.size(), 32);
    check("bp_bytes", byte_errs(32), 0);
    check("bp_stall_hold", stall_bad, 0);
    check("bp_addr_seq", addr_errs(2), 0);
    check("bp_done_count", done_cnt, 1);

    // Zero length
    run_unload(0, 0, 0);
    check("z_valid_cycles", valid_cnt, 0);
    check("z_done_cycle", done_cyc, 2);
    check("z_done_count", done_cnt, 1);

    // Start while busy is ignored
    run_unload(1, 0, 6);
    check("sb_count", got.size(), 16);
    check("sb_bytes", byte_errs(16), 0);
    check("sb_max_addr", max_addr, 0);
    check("sb_done_count", done_cnt, 1);

    // All-0xFF word, sum of 16 bytes = 0x0FF0
    mem[0] = {128{1'b1}};
    run_unload(1, 0, 0);
    check("ff_bytes", byte_errs(16), 0);
`ifdef OUTPUT_UNLOAD_CHECKSUM_EN
    check("ff_checksum", 32'(Checksum), 32'h0FF0);
`endif
    for (int b = 0; b < 16; b++) mem[0][8 * b +: 8] = 8'(b);

    // Reset mid-stream after byte 20 of a three-word unload
    @(negedge clock);
    start = 1'b1; NumWords = 16'd3; PixelReady = 1'b1;
    @(negedge clock);
    start = 1'b0;
    cnt = 0;
    for (int n = 0; n < 100 && cnt < 21; n++) begin
      if (PixelValid && PixelReady) cnt++;
      if (cnt < 21) @(negedge clock);
    end
    check("mr_reached_byte20", cnt, 21);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("mr_addr",  32'(Output_ReadAddress), 0);
    check("mr_pix",   32'(PixelOut), 0);
    check("mr_valid", 32'(PixelValid), 0);
    check("mr_busy",  32'(Busy), 0);
    check("mr_done",  32'(done), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check("mr_idle_valid", 32'(PixelValid), 0);
    run_unload(1, 0, 0);
    check("mr_restart_addr", addr_errs(1), 0);
    check("mr_restart_first", first_v, 3);
    check("mr_restart_bytes", byte_errs(16), 0);
    check("mr_restart_count", got.size(), 16);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
